// File: rtl/pc_sequencer.sv
// Fetch/branch sequencer: latches each instruction, computes the next PC and strobes en_pc once per instruction.
// Latency: 4 cycles per instruction minimum, plus one cycle for each FETCH cycle with mem_ready low.
// Backpressure: the sequencer stalls in FETCH until mem_ready is high; there is no other flow control.
module pc_sequencer #(
   parameter int              PC_W      = 16,
   parameter logic [3:0]      UC_COND   = 4'hE,
   parameter logic [PC_W-1:0] HALT_WORD = {PC_W{1'b1}}
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [PC_W-1:0] pc_current,
   input  logic [PC_W-1:0] instr,
   input  logic            mem_ready,
   input  logic            flag_z,
   input  logic            flag_c,
   input  logic            flag_n,
   input  logic [PC_W-1:0] rtarget,
   output logic [PC_W-1:0] in_pc,
   output logic            en_pc,
   output logic [PC_W-1:0] ir,
   output logic            exec_en,
   output logic            halted
);

   typedef enum logic [2:0] {
      ST_FETCH  = 3'd0,
      ST_DECODE = 3'd1,
      ST_EXEC   = 3'd2,
      ST_UPDATE = 3'd3,
      ST_HALT   = 3'd4
   } state_t;

   localparam logic [PC_W-1:0] PC_ONE = {{(PC_W-1){1'b0}}, 1'b1};

   state_t          state_q;
   state_t          state_d;
   logic [PC_W-1:0] ir_q;
   logic [PC_W-1:0] ir_d;
   logic [PC_W-1:0] in_pc_q;
   logic [PC_W-1:0] in_pc_d;

   logic [3:0]      opcode;
   logic [3:0]      cond;
   logic [3:0]      subop;
   logic            is_bcond;
   logic            is_jcond;
   logic            taken;
   logic [PC_W-1:0] disp_ext;
   logic [PC_W-1:0] pc_inc;
   logic [PC_W-1:0] pc_rel;

   // Instruction field decode from the latched word, so fields are stable through EXEC.
   assign opcode   = ir_q[15:12];
   assign cond     = ir_q[11:8];
   assign subop    = ir_q[7:4];
   assign is_bcond = (opcode == 4'hC);
   assign is_jcond = (opcode == 4'h4) && (subop == 4'hC);
   assign disp_ext = {{(PC_W-8){ir_q[7]}}, ir_q[7:0]};
   assign pc_inc   = pc_current + PC_ONE;
   assign pc_rel   = pc_current + disp_ext;

   always_comb begin
      taken = 1'b0;
      if (cond == UC_COND) begin
         taken = 1'b1;
      end else begin
         case (cond)
            4'h0:    taken = flag_z;
            4'h1:    taken = ~flag_z;
            4'h2:    taken = flag_c;
            4'h3:    taken = ~flag_c;
            4'h4:    taken = flag_n;
            4'h5:    taken = ~flag_n;
            default: taken = 1'b0;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= ST_FETCH;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_FETCH:  if (mem_ready) state_d = ST_DECODE;
         ST_DECODE: state_d = (ir_q == HALT_WORD) ? ST_HALT : ST_EXEC;
         ST_EXEC:   state_d = ST_UPDATE;
         ST_UPDATE: state_d = ST_FETCH;
         ST_HALT:   state_d = ST_HALT;
         default:   state_d = ST_FETCH;
      endcase
   end

   always_comb begin
      en_pc   = 1'b0;
      exec_en = 1'b0;
      halted  = 1'b0;
      case (state_q)
         ST_EXEC:   exec_en = 1'b1;
         ST_UPDATE: en_pc   = 1'b1;
         ST_HALT:   halted  = 1'b1;
         default:   ;
      endcase
   end

   // in_pc is only recomputed in EXEC so the PC register sees a stable value during UPDATE.
   always_comb begin
      ir_d    = ir_q;
      in_pc_d = in_pc_q;
      if ((state_q == ST_FETCH) && mem_ready) begin
         ir_d = instr;
      end
      if (state_q == ST_EXEC) begin
         if (is_bcond && taken) begin
            in_pc_d = pc_rel;
         end else if (is_jcond && taken) begin
            in_pc_d = rtarget;
         end else begin
            in_pc_d = pc_inc;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ir_q    <= '0;
         in_pc_q <= '0;
      end else begin
         ir_q    <= ir_d;
         in_pc_q <= in_pc_d;
      end
   end

   assign in_pc = in_pc_q;
   assign ir    = ir_q;

endmodule
